// File: rtl/popcount22_neuron_seq.sv
// Purpose: time-shares one external 22-input popcount core across N_NEURONS
// ternary neurons. For each accepted word, every neuron gets a positive-mask
// popcount followed by a negative-mask popcount. The difference is compared
// against that neuron's signed threshold to give one fire bit per neuron.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input word handshake, in_data = 22-bit activations
//   pos_mask/neg_mask   per-neuron 22-bit weight masks, neuron k at [22k+21:22k]
//   thr                 per-neuron signed threshold, neuron k at [THR_W*k +: THR_W]
//   pc_in/pc_out        operand to / result from the shared combinational popcount core
//   out_valid/out_ready result handshake, out_data bit k = neuron k fire bit
//   busy                high whenever a word is in flight or awaiting handoff
module popcount22_neuron_seq #(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned THR_W     = 7,
  parameter int unsigned PC_W      = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [21:0]                in_data,
  input  logic [22*N_NEURONS-1:0]    pos_mask,
  input  logic [22*N_NEURONS-1:0]    neg_mask,
  input  logic [THR_W*N_NEURONS-1:0] thr,
  output logic [21:0]                pc_in,
  input  logic [PC_W-1:0]            pc_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_NEURONS-1:0]       out_data,
  output logic                       busy
);

  localparam int unsigned IN_W  = 22;
  localparam int unsigned IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int unsigned D_W   = PC_W + 2;
  localparam int unsigned CMP_W = (D_W > THR_W) ? D_W : THR_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, POS, NEG, DONE} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IN_W-1:0]        x_q, x_d;
  logic [PC_W-1:0]        pos_acc_q, pos_acc_d;
  logic [N_NEURONS-1:0]   res_q, res_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [N_NEURONS-1:0]   out_data_q, out_data_d;
  logic                   busy_q, busy_d;

  logic [IN_W-1:0]        pos_sel_c, neg_sel_c;
  logic [THR_W-1:0]       thr_sel_c;
  logic signed [D_W-1:0]  d_c;
  logic signed [CMP_W-1:0] d_ext_c, thr_ext_c;
  logic                   fire_c;

  // Pick the current neuron's masks and threshold (read live each phase).
  always_comb begin
    pos_sel_c = '0;
    neg_sel_c = '0;
    thr_sel_c = '0;
    for (int unsigned k = 0; k < N_NEURONS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        pos_sel_c = pos_mask[k*IN_W +: IN_W];
        neg_sel_c = neg_mask[k*IN_W +: IN_W];
        thr_sel_c = thr[k*THR_W +: THR_W];
      end
    end
  end

  // Signed difference pos - neg; two guard bits make it overflow-free even
  // for approximate-core results up to 2^PC_W-1.
  always_comb begin
    d_c       = $signed({2'b00, pos_acc_q}) - $signed({2'b00, pc_out});
    d_ext_c   = CMP_W'(d_c);
    thr_ext_c = CMP_W'($signed(thr_sel_c));
    fire_c    = (d_ext_c >= thr_ext_c);
  end

  // Core operand is zero outside the count phases to keep the core quiet.
  always_comb begin
    pc_in = '0;
    case (state_q)
      POS:     pc_in = x_q & pos_sel_c;
      NEG:     pc_in = x_q & neg_sel_c;
      default: pc_in = '0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    x_d       = x_q;
    pos_acc_d = pos_acc_q;
    res_d     = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          idx_d   = '0;
          res_d   = '0;
          state_d = POS;
        end
      end
      POS: begin
        pos_acc_d = pc_out;
        state_d   = NEG;
      end
      NEG: begin
        res_d[idx_q] = fire_c;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = POS;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    out_data_d  = (state_d == DONE) ? res_d : '0;
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      x_q         <= '0;
      pos_acc_q   <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      pos_acc_q   <= pos_acc_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_popcount22_neuron_seq.sv
// Bench for popcount22_neuron_seq with N_NEURONS=4, THR_W=7, PC_W=5.
// The popcount core is modelled as an exact popcount, or a constant-31 stub.
module tb_popcount22_neuron_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] in_data;
  logic [87:0] pos_mask;
  logic [87:0] neg_mask;
  logic [27:0] thr;
  logic [21:0] pc_in;
  logic [4:0]  pc_out;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        busy;
  logic        approx;

  int   tests_run    = 0;
  int   tests_failed = 0;
  logic [3:0] sb[$];
  time  accept_t;

  always #5 clk = ~clk;

  assign pc_out = approx ? 5'd31 : 5'($countones(pc_in));

  popcount22_neuron_seq #(.N_NEURONS(4), .THR_W(7), .PC_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .pos_mask(pos_mask), .neg_mask(neg_mask), .thr(thr),
    .pc_in(pc_in), .pc_out(pc_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  // Reference fire bits for one word.
  function automatic logic [3:0] model_fire(input logic [21:0] x, input logic [87:0] pm,
                                            input logic [87:0] nm, input logic [27:0] th,
                                            input logic apx);
    logic [3:0]        r;
    logic [21:0]       pk, nk;
    logic signed [6:0] t;
    int                p, n, ti;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      pk = pm[k*22 +: 22];
      nk = nm[k*22 +: 22];
      t  = th[k*7 +: 7];
      ti = t;
      p  = apx ? 31 : $countones(x & pk);
      n  = apx ? 31 : $countones(x & nk);
      r[k] = ((p - n) >= ti);
    end
    return r;
  endfunction

  task automatic set_neuron(input int k, input logic [21:0] pm, input logic [21:0] nm,
                            input logic [6:0] t);
    pos_mask[k*22 +: 22] = pm;
    neg_mask[k*22 +: 22] = nm;
    thr[k*7 +: 7]        = t;
  endtask

  task automatic clear_neurons();
    for (int k = 0; k < 4; k++) set_neuron(k, 22'h0, 22'h0, 7'd63);
  endtask

  // Present a word, wait for acceptance, push its expected result.
  task automatic send_word(input logic [21:0] x, input logic hold_valid);
    int n;
    n = 0;
    in_data  = x;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    tests_run++;
    if (n >= 40) begin
      tests_failed++;
      $display("FAIL accept_timeout: in_ready %b after %0d cycles, required 1", in_ready, n);
    end
    sb.push_back(model_fire(x, pos_mask, neg_mask, thr, approx));
    @(posedge clk);
    accept_t = $time;
    #1;
    if (hold_valid) in_data = 22'($urandom);
    else in_valid = 1'b0;
  endtask

  // Wait for out_valid, check latency and scoreboard, return observed data.
  task automatic wait_out(input string name, output logic [3:0] got);
    int lat;
    logic [3:0] exp;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    got = out_data;
    tests_run++;
    if (lat != 8) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d cycles, required 8", name, lat);
    end
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL %s_scoreboard: output %b with no expected entry", name, got);
    end else begin
      exp = sb.pop_front();
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL %s_data: got %b, required %b", name, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({in_ready, out_valid, out_data, pc_in, busy} !== {1'b1, 1'b0, 4'h0, 22'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_data=%h pc_in=%h busy=%b, required 1 0 0 0 0",
               in_ready, out_valid, out_data, pc_in, busy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_fire();
    logic [3:0] got;
    clear_neurons();
    set_neuron(0, 22'h3FFFFF, 22'h0, 7'd22);
    send_word(22'h3FFFFF, 1'b0);
    wait_out("single", got);
    tests_run++;
    if (got !== 4'b0001) begin
      tests_failed++;
      $display("FAIL single_const: got %b, required 0001", got);
    end
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_return_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_zero_diff();
    logic [3:0] got;
    clear_neurons();
    set_neuron(1, 22'h00000F, 22'h0000F0, 7'd0);
    set_neuron(2, 22'h00000F, 22'h0000F0, 7'd1);
    send_word(22'h0000FF, 1'b0);
    wait_out("zero_diff", got);
    tests_run++;
    if (got !== 4'b0010) begin
      tests_failed++;
      $display("FAIL zero_diff_const: got %b, required 0010", got);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_negative_thr();
    logic [3:0] got;
    clear_neurons();
    set_neuron(3, 22'h0, 22'h00001F, 7'h7B);
    send_word(22'h3FFFFF, 1'b0);
    wait_out("neg_thr_m5", got);
    tests_run++;
    if (got !== 4'b1000) begin
      tests_failed++;
      $display("FAIL neg_thr_m5_const: got %b, required 1000", got);
    end
    @(posedge clk); #1;
    set_neuron(3, 22'h0, 22'h00001F, 7'h7C);
    send_word(22'h3FFFFF, 1'b0);
    wait_out("neg_thr_m4", got);
    tests_run++;
    if (got !== 4'b0000) begin
      tests_failed++;
      $display("FAIL neg_thr_m4_const: got %b, required 0000", got);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [3:0] got;
    clear_neurons();
    set_neuron(0, 22'h0000FF, 22'h000F00, 7'd2);
    set_neuron(2, 22'h3F0000, 22'h0, 7'd5);
    out_ready = 1'b0;
    send_word(22'h35A5A5, 1'b0);
    wait_out("bp", got);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== got || in_ready !== 1'b0 || pc_in !== 22'h0) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: out_valid=%b out_data=%b in_ready=%b pc_in=%h, required 1 %b 0 0",
                 i, out_valid, out_data, in_ready, pc_in, got);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] got;
    logic [21:0] x;
    x = 22'h2C3A17;
    clear_neurons();
    set_neuron(1, 22'h00FF00, 22'h0000FF, 7'h7E);
    set_neuron(2, 22'h0F0F0F, 22'h30F0F0, 7'd0);
    send_word(x, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1 || pc_in !== (x & 22'h30F0F0)) begin
      tests_failed++;
      $display("FAIL mid_reset_neg2: busy=%b pc_in=%h, required 1 %h", busy, pc_in, x & 22'h30F0F0);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(sb.pop_back());
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || pc_in !== 22'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_idle: out_valid=%b busy=%b in_ready=%b pc_in=%h, required 0 0 1 0",
               out_valid, busy, in_ready, pc_in);
    end
    send_word(22'h155555, 1'b0);
    wait_out("after_reset", got);
    @(posedge clk); #1;
  endtask

  task automatic test_approx();
    logic [3:0] got;
    for (int k = 0; k < 4; k++) set_neuron(k, 22'h3FFFFF, 22'h000001, 7'd0);
    approx = 1'b1;
    send_word(22'h0F0F0F, 1'b0);
    wait_out("approx", got);
    tests_run++;
    if (got !== 4'b1111) begin
      tests_failed++;
      $display("FAIL approx_const: got %b, required 1111", got);
    end
    @(posedge clk); #1;
    approx = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] got;
    time prev_t;
    pos_mask = 88'({$urandom, $urandom, $urandom});
    neg_mask = 88'({$urandom, $urandom, $urandom});
    thr      = 28'($urandom);
    prev_t   = 0;
    for (int i = 0; i < 5; i++) begin
      send_word(22'($urandom), 1'b1);
      if (i > 0) begin
        tests_run++;
        if (accept_t - prev_t != 100) begin
          tests_failed++;
          $display("FAIL b2b_period_%0d: got %0t, required 100", i, accept_t - prev_t);
        end
      end
      prev_t = accept_t;
      wait_out("b2b", got);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded", $time);
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    approx    = 1'b0;
    pos_mask  = '0;
    neg_mask  = '0;
    thr       = '0;
    test_reset();
    test_single_fire();
    test_zero_diff();
    test_negative_thr();
    test_backpressure();
    test_mid_reset();
    test_approx();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
